// File: rtl/ls_functional_unit.sv
`default_nettype none
// ============================================================================
// Module   : ls_functional_unit
// Brief    : Single-outstanding LDUR/STUR unit between the RS issue port,
//            data memory and ROB completion port.
// Revision : 1.0
// ============================================================================

package ls_functional_unit_pkg;
  typedef logic [1:0] fu_op_t;
  localparam fu_op_t FU_OP_NOP  = 2'd0;
  localparam fu_op_t FU_OP_LDUR = 2'd1;
  localparam fu_op_t FU_OP_STUR = 2'd2;
endpackage

module ls_functional_unit
  import ls_functional_unit_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int ROB_IDX_W  = 4,
  parameter int ALIGN_BITS = 3
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_rs_start,
  input  fu_op_t               in_rs_op,
  input  logic [DATA_W-1:0]    in_rs_val_a,
  input  logic [DATA_W-1:0]    in_rs_val_b,
  input  logic [ROB_IDX_W-1:0] in_rs_dst_rob_index,
  output logic                 out_fu_ready,
  output logic                 out_mem_req_valid,
  input  logic                 in_mem_req_ready,
  output logic                 out_mem_req_we,
  output logic [DATA_W-1:0]    out_mem_addr,
  output logic [DATA_W-1:0]    out_mem_wdata,
  input  logic                 in_mem_resp_valid,
  input  logic [DATA_W-1:0]    in_mem_rdata,
  input  logic                 in_rob_is_mispred,
  output logic                 out_rob_done,
  output logic [ROB_IDX_W-1:0] out_rob_dst_rob_index,
  output logic [DATA_W-1:0]    out_rob_value,
  output logic                 out_rob_fault
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 r_state;
  fu_op_t                 r_op;
  logic [DATA_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic [ROB_IDX_W-1:0]   r_dst;
  logic [DATA_W-1:0]      r_value;
  logic                   r_fault;
  logic                   r_kill;

  logic w_valid_op;
  logic w_accept;
  logic w_misaligned;
  logic w_mem_fire;
  logic w_done;

  assign w_valid_op   = (in_rs_op == FU_OP_LDUR) || (in_rs_op == FU_OP_STUR);
  assign out_fu_ready = (r_state == S_IDLE) && !in_rst;
  assign w_accept     = in_rs_start && out_fu_ready && w_valid_op && !in_rob_is_mispred;
  assign w_misaligned = |in_rs_val_a[ALIGN_BITS-1:0];
  assign w_mem_fire   = (r_state == S_REQ) && in_mem_req_ready;

  assign out_mem_req_valid = (r_state == S_REQ);
  assign out_mem_req_we    = (r_op == FU_OP_STUR);
  assign out_mem_addr      = r_addr;
  assign out_mem_wdata     = r_wdata;

  // A flush arriving in the completion cycle cancels the pulse itself.
  assign w_done                = (r_state == S_DONE) && !in_rob_is_mispred;
  assign out_rob_done          = w_done;
  assign out_rob_dst_rob_index = w_done ? r_dst   : '0;
  assign out_rob_value         = w_done ? r_value : '0;
  assign out_rob_fault         = w_done ? r_fault : 1'b0;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_state <= S_IDLE;
      r_op    <= FU_OP_NOP;
      r_addr  <= '0;
      r_wdata <= '0;
      r_dst   <= '0;
      r_value <= '0;
      r_fault <= 1'b0;
      r_kill  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= in_rs_op;
            r_addr  <= in_rs_val_a;
            r_wdata <= in_rs_val_b;
            r_dst   <= in_rs_dst_rob_index;
            r_value <= '0;
            r_kill  <= 1'b0;
            r_fault <= w_misaligned;
            r_state <= w_misaligned ? S_DONE : S_REQ;
          end
        end
        S_REQ: begin
          if (w_mem_fire) begin
            if (r_op == FU_OP_STUR) begin
              r_state <= in_rob_is_mispred ? S_IDLE : S_DONE;
            end else begin
              // The load is already in memory; remember to discard its data.
              r_state <= S_WAIT;
              r_kill  <= in_rob_is_mispred;
            end
          end else if (in_rob_is_mispred) begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (in_mem_resp_valid) begin
            if (r_kill || in_rob_is_mispred) begin
              r_state <= S_IDLE;
              r_kill  <= 1'b0;
            end else begin
              r_value <= in_mem_rdata;
              r_state <= S_DONE;
            end
          end else if (in_rob_is_mispred) begin
            r_kill <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ls_functional_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ls_functional_unit
// Brief    : Scoreboard bench for ls_functional_unit with a memory responder.
// Revision : 1.0
// ============================================================================

module tb_ls_functional_unit;
  import ls_functional_unit_pkg::*;

  logic        clk;
  logic        in_rst;
  logic        in_rs_start;
  fu_op_t      in_rs_op;
  logic [63:0] in_rs_val_a;
  logic [63:0] in_rs_val_b;
  logic [3:0]  in_rs_dst_rob_index;
  logic        out_fu_ready;
  logic        out_mem_req_valid;
  logic        in_mem_req_ready;
  logic        out_mem_req_we;
  logic [63:0] out_mem_addr;
  logic [63:0] out_mem_wdata;
  logic        in_mem_resp_valid;
  logic [63:0] in_mem_rdata;
  logic        in_rob_is_mispred;
  logic        out_rob_done;
  logic [3:0]  out_rob_dst_rob_index;
  logic [63:0] out_rob_value;
  logic        out_rob_fault;

  ls_functional_unit #(.DATA_W(64), .ROB_IDX_W(4), .ALIGN_BITS(3)) dut (
    .in_clk(clk), .in_rst(in_rst),
    .in_rs_start(in_rs_start), .in_rs_op(in_rs_op),
    .in_rs_val_a(in_rs_val_a), .in_rs_val_b(in_rs_val_b),
    .in_rs_dst_rob_index(in_rs_dst_rob_index),
    .out_fu_ready(out_fu_ready),
    .out_mem_req_valid(out_mem_req_valid), .in_mem_req_ready(in_mem_req_ready),
    .out_mem_req_we(out_mem_req_we), .out_mem_addr(out_mem_addr),
    .out_mem_wdata(out_mem_wdata),
    .in_mem_resp_valid(in_mem_resp_valid), .in_mem_rdata(in_mem_rdata),
    .in_rob_is_mispred(in_rob_is_mispred),
    .out_rob_done(out_rob_done), .out_rob_dst_rob_index(out_rob_dst_rob_index),
    .out_rob_value(out_rob_value), .out_rob_fault(out_rob_fault)
  );

  typedef struct {
    logic [3:0]  dst;
    logic [63:0] value;
    logic        fault;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] mem[logic [63:0]];
  logic [63:0] ref_mem[logic [63:0]];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_done = 0;
  int n_req = 0;
  int n_writes = 0;
  bit rnd_ready = 0;
  bit resp_rand = 0;
  int resp_delay = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // cyc == k during the clock period that follows rising edge k.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] init_val(input logic [63:0] a);
    return {a[31:0], ~a[31:0]} ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every completion pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_rob_done) begin
        n_done++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: dst=%0d value=%0h fault=%0b, expected no completion",
                   out_rob_dst_rob_index, out_rob_value, out_rob_fault);
        end else begin
          e = exp_q.pop_front();
          chk("done_dst", 64'(out_rob_dst_rob_index), 64'(e.dst));
          chk("done_value", out_rob_value, e.value);
          chk("done_fault", 64'(out_rob_fault), 64'(e.fault));
        end
      end else begin
        chk("idle_rob_outputs_zero",
            out_rob_value | 64'(out_rob_dst_rob_index) | 64'(out_rob_fault), 64'd0);
      end
    end
  end

  // Memory responder: records writes, returns load data after a delay.
  initial begin
    bit          new_load = 0;
    bit          pend = 0;
    int          cnt = 0;
    logic [63:0] load_addr = '0;
    logic [63:0] pend_data = '0;
    forever begin
      @(negedge clk);
      if (out_mem_req_valid && in_mem_req_ready) begin
        n_req++;
        if (out_mem_req_we) begin
          mem[out_mem_addr] = out_mem_wdata;
          n_writes++;
        end else begin
          new_load  = 1;
          load_addr = out_mem_addr;
        end
      end
      @(posedge clk);
      #1;
      if (rnd_ready) in_mem_req_ready = ($urandom_range(0, 3) != 0);
      if (new_load) begin
        pend      = 1;
        cnt       = resp_rand ? int'($urandom_range(0, 3)) : resp_delay;
        pend_data = mem.exists(load_addr) ? mem[load_addr] : init_val(load_addr);
        new_load  = 0;
      end
      in_mem_resp_valid = 0;
      if (pend) begin
        if (cnt == 0) begin
          in_mem_resp_valid = 1;
          in_mem_rdata      = pend_data;
          pend              = 0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Drives one issue when the unit is ready; acc is the edge that takes it.
  task automatic issue(input fu_op_t op, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] dst, input bit push, output int acc);
    exp_t e;
    int   n = 0;
    acc = -1;
    while (!out_fu_ready && n < 200) begin
      step();
      n++;
    end
    if (!out_fu_ready) begin
      chk("issue_ready_timeout", 64'(out_fu_ready), 64'd1);
      return;
    end
    in_rs_start         = 1;
    in_rs_op            = op;
    in_rs_val_a         = a;
    in_rs_val_b         = b;
    in_rs_dst_rob_index = dst;
    acc                 = cyc + 1;
    if (push && (op == FU_OP_LDUR || op == FU_OP_STUR)) begin
      e.dst = dst;
      if (a[2:0] != 3'd0) begin
        e.value = '0;
        e.fault = 1;
      end else if (op == FU_OP_STUR) begin
        ref_mem[a] = b;
        e.value    = '0;
        e.fault    = 0;
      end else begin
        e.value = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
        e.fault = 0;
      end
      exp_q.push_back(e);
    end
    step();
    in_rs_start = 0;
    in_rs_op    = fu_op_t'($urandom_range(0, 3));
    in_rs_val_a = {$urandom, $urandom};
    in_rs_val_b = {$urandom, $urandom};
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_rob_done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int acc, at, r0, w0, d0;
    in_rst = 1; in_rs_start = 0; in_rs_op = FU_OP_NOP;
    in_rs_val_a = '0; in_rs_val_b = '0; in_rs_dst_rob_index = '0;
    in_mem_req_ready = 0; in_mem_resp_valid = 0; in_mem_rdata = '0;
    in_rob_is_mispred = 0;
    mem[64'h100]     = 64'hDEAD;
    ref_mem[64'h100] = 64'hDEAD;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_ready_low", 64'(out_fu_ready), 64'd0);
    step();
    in_rst = 0;
    @(negedge clk);
    chk("reset_ready", 64'(out_fu_ready), 64'd1);
    chk("reset_req_valid", 64'(out_mem_req_valid), 64'd0);
    chk("reset_done", 64'(out_rob_done), 64'd0);
    chk("reset_addr", out_mem_addr, 64'd0);
    chk("reset_wdata", out_mem_wdata, 64'd0);
    chk("reset_we", 64'(out_mem_req_we), 64'd0);
    step();

    // Load with no stalls; done in spec cycle N+3 (cyc acc+2).
    in_mem_req_ready = 1; resp_delay = 0;
    issue(FU_OP_LDUR, 64'h100, 64'h5555, 4'd5, 1, acc);
    @(negedge clk);
    chk("load_req_valid", 64'(out_mem_req_valid), 64'd1);
    chk("load_req_we", 64'(out_mem_req_we), 64'd0);
    chk("load_req_addr", out_mem_addr, 64'h100);
    chk("load_busy", 64'(out_fu_ready), 64'd0);
    wait_done(at);
    chk("load_latency", 64'(at), 64'(acc + 2));
    chk("load_busy_at_done", 64'(out_fu_ready), 64'd0);
    @(negedge clk);
    chk("load_ready_after_done", 64'(out_fu_ready), 64'd1);
    step();

    // Store held off by memory for three cycles.
    in_mem_req_ready = 0; w0 = n_writes;
    issue(FU_OP_STUR, 64'h208, 64'd42, 4'd3, 1, acc);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("store_hold_valid", 64'(out_mem_req_valid), 64'd1);
      chk("store_hold_addr", out_mem_addr, 64'h208);
      chk("store_hold_wdata", out_mem_wdata, 64'd42);
      chk("store_hold_we", 64'(out_mem_req_we), 64'd1);
    end
    step();
    in_mem_req_ready = 1;
    wait_done(at);
    chk("store_latency", 64'(at), 64'(acc + 4));
    chk("store_write_count", 64'(n_writes - w0), 64'd1);
    chk("store_mem_data", mem.exists(64'h208) ? mem[64'h208] : 64'hX, 64'd42);
    step();

    // Misaligned load faults immediately without touching memory.
    r0 = n_req;
    issue(FU_OP_LDUR, 64'h104, 64'd0, 4'd7, 1, acc);
    wait_done(at);
    chk("fault_latency", 64'(at), 64'(acc));
    chk("fault_no_req_valid", 64'(out_mem_req_valid), 64'd0);
    @(negedge clk);
    chk("fault_no_mem_req", 64'(n_req - r0), 64'd0);
    step();

    // Flush while waiting on a load; response two cycles later is dropped.
    resp_delay = 2;
    issue(FU_OP_LDUR, 64'h300, 64'd0, 4'd9, 0, acc);
    step();
    in_rob_is_mispred = 1;
    step();
    in_rob_is_mispred = 0;
    d0 = n_done;
    @(negedge clk);
    chk("flushwait_busy_1", 64'(out_fu_ready), 64'd0);
    @(negedge clk);
    chk("flushwait_busy_resp", 64'(out_fu_ready), 64'd0);
    @(negedge clk);
    chk("flushwait_ready_after_resp", 64'(out_fu_ready), 64'd1);
    repeat (3) @(negedge clk);
    chk("flushwait_no_done", 64'(n_done - d0), 64'd0);
    step();
    resp_delay = 0;

    // Flush of a store stalled in REQ.
    in_mem_req_ready = 0; w0 = n_writes; d0 = n_done;
    issue(FU_OP_STUR, 64'h400, 64'd77, 4'd2, 0, acc);
    @(negedge clk);
    chk("flushreq_valid_before", 64'(out_mem_req_valid), 64'd1);
    step();
    in_rob_is_mispred = 1;
    step();
    in_rob_is_mispred = 0;
    @(negedge clk);
    chk("flushreq_valid_dropped", 64'(out_mem_req_valid), 64'd0);
    chk("flushreq_ready", 64'(out_fu_ready), 64'd1);
    step();
    in_mem_req_ready = 1;
    repeat (3) @(negedge clk);
    chk("flushreq_no_write", 64'(n_writes - w0), 64'd0);
    chk("flushreq_no_done", 64'(n_done - d0), 64'd0);
    step();

    // Start coinciding with a flush is ignored.
    r0 = n_req; d0 = n_done;
    in_rs_start = 1; in_rs_op = FU_OP_LDUR; in_rs_val_a = 64'h700;
    in_rs_dst_rob_index = 4'd1; in_rob_is_mispred = 1;
    step();
    in_rs_start = 0; in_rob_is_mispred = 0;
    @(negedge clk);
    chk("startflush_ready", 64'(out_fu_ready), 64'd1);
    chk("startflush_no_valid", 64'(out_mem_req_valid), 64'd0);
    repeat (3) @(negedge clk);
    chk("startflush_no_req", 64'(n_req - r0), 64'd0);
    chk("startflush_no_done", 64'(n_done - d0), 64'd0);
    step();

    // Start while busy is ignored; the original store completes alone.
    in_mem_req_ready = 0; r0 = n_req;
    issue(FU_OP_STUR, 64'h500, 64'd11, 4'd4, 1, acc);
    in_rs_start = 1; in_rs_op = FU_OP_LDUR; in_rs_val_a = 64'h508;
    in_rs_dst_rob_index = 4'd6;
    step();
    in_rs_start = 0;
    @(negedge clk);
    chk("busy_addr_kept", out_mem_addr, 64'h500);
    chk("busy_we_kept", 64'(out_mem_req_we), 64'd1);
    step();
    in_mem_req_ready = 1;
    wait_done(at);
    chk("busy_store_latency", 64'(at), 64'(acc + 3));
    repeat (3) @(negedge clk);
    chk("busy_single_req", 64'(n_req - r0), 64'd1);
    step();

    // Reset in WAIT, stray response afterwards.
    resp_delay = 4; d0 = n_done;
    issue(FU_OP_LDUR, 64'h600, 64'd0, 4'd8, 0, acc);
    step();
    in_rst = 1;
    @(negedge clk);
    chk("rstwait_ready_low", 64'(out_fu_ready), 64'd0);
    step();
    @(negedge clk);
    chk("rstwait_valid", 64'(out_mem_req_valid), 64'd0);
    chk("rstwait_addr", out_mem_addr, 64'd0);
    chk("rstwait_wdata", out_mem_wdata, 64'd0);
    chk("rstwait_we", 64'(out_mem_req_we), 64'd0);
    step();
    in_rst = 0;
    @(negedge clk);
    chk("rstwait_ready_after", 64'(out_fu_ready), 64'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rstwait_stray_no_done", 64'(out_rob_done), 64'd0);
    end
    chk("rstwait_no_done_total", 64'(n_done - d0), 64'd0);
    step();
    resp_delay = 0;

    // Randomized traffic against the reference memory.
    rnd_ready = 1; resp_rand = 1;
    for (int i = 0; i < 300; i++) begin
      fu_op_t      op;
      logic [63:0] a;
      int          r;
      repeat ($urandom_range(0, 2)) step();
      a = 64'h1000 + 64'($urandom_range(0, 15)) * 64'd8;
      if ($urandom_range(0, 9) == 0) a = a + 64'($urandom_range(1, 7));
      r = int'($urandom_range(0, 9));
      if (r < 5)      op = FU_OP_LDUR;
      else if (r < 9) op = FU_OP_STUR;
      else            op = ($urandom_range(0, 1) == 0) ? FU_OP_NOP : 2'd3;
      issue(op, a, {$urandom, $urandom}, 4'($urandom), 1, acc);
    end
    for (int k = 0; k < 200 && exp_q.size() > 0; k++) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ls_functional_unit.md
Name: ls_functional_unit

Overview:
- Load/store functional unit on the FU side of the reservation-station issue interface.
- Accepts one issued LDUR/STUR op per handshake: start, op, effective address, store data and destination ROB index.
- Runs a single-outstanding data-memory transaction for the op.
- Reports completion (load value or store ack, plus fault) to the ROB, and drives the ready signal back to the reservation station.

Parameters:
- DATA_W, 64, width of GPR values, address and memory data (`GPR_SIZE`).
- ROB_IDX_W, 4, width of ROB indices (`ROB_IDX_SIZE`).
- ALIGN_BITS, 3, low address bits that must be zero (8-byte access).

Ports:
- in_clk  in  1  clock; all state changes on its rising edge.
- in_rst  in  1  synchronous, active-high reset.
- in_rs_start  in  1  reservation station issues an op this cycle.
- in_rs_op  in  fu_op_t  FU_OP_LDUR or FU_OP_STUR; any other value is treated as no-op.
- in_rs_val_a  in  DATA_W  effective address (base+offset already summed upstream).
- in_rs_val_b  in  DATA_W  store data (ignored for loads).
- in_rs_dst_rob_index  in  ROB_IDX_W  ROB entry to complete.
- out_fu_ready  out  1  unit can accept an issue this cycle.
- out_mem_req_valid  out  1  memory request valid.
- in_mem_req_ready  in  1  memory accepts the request.
- out_mem_req_we  out  1  1 = store, 0 = load.
- out_mem_addr  out  DATA_W  request address.
- out_mem_wdata  out  DATA_W  store data.
- in_mem_resp_valid  in  1  load data return (loads only; stores get no response).
- in_mem_rdata  in  DATA_W  load data.
- in_rob_is_mispred  in  1  flush of all in-flight speculative work.
- out_rob_done  out  1  one-cycle completion pulse.
- out_rob_dst_rob_index  out  ROB_IDX_W  completing ROB entry.
- out_rob_value  out  DATA_W  load data; 0 for stores and faults.
- out_rob_fault  out  1  misaligned access.

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Registered fields: op, addr, wdata, dst index, value, fault, kill.
- out_fu_ready = (state == IDLE) and not in_rst (combinational).
- Issue acceptance:
  - Accepted at an edge with in_rs_start & out_fu_ready & valid op & ~in_rob_is_mispred.
  - All op fields are latched at that edge.
  - Start while not ready, with an invalid op, or coinciding with a flush is ignored.
- Misalignment check at acceptance: if addr[ALIGN_BITS-1:0] != 0, go straight to DONE with fault=1 and value=0. No memory request is made.
- IDLE -> REQ on an aligned accept. out_mem_req_valid = (state == REQ); addr/we/wdata come from the latched fields.
- REQ:
  - At the edge where valid & in_mem_req_ready: store -> DONE, load -> WAIT.
  - Otherwise stay in REQ.
  - Address and data are held stable while waiting.
- WAIT: on in_mem_resp_valid, capture in_mem_rdata into value and go to DONE. No timeout.
- DONE:
  - out_rob_done = 1 for exactly one cycle, with dst/value/fault from registers; then IDLE.
  - Outputs are 0 whenever out_rob_done = 0.
- Latency (no memory stalls):
  - Store: accept edge N; request visible in cycle N+1 and accepted at edge N+1; done visible in cycle N+2.
  - Load, response in the cycle after acceptance: done visible in cycle N+3.
  - Fault: done visible in cycle N+1.
- Flush (in_rob_is_mispred sampled high at an edge):
  - REQ, not accepted at this edge: drop the request and go to IDLE; no memory access, no done.
  - REQ, accepted at the same edge: a store goes to IDLE with no done (the write has occurred). A load goes to WAIT with kill=1.
  - WAIT: set kill=1, keep waiting. When the response arrives, discard it and go to IDLE with no done.
  - DONE: suppress the done pulse, go to IDLE.
  - IDLE: no effect.
- Only one transaction is outstanding at a time. in_mem_resp_valid outside WAIT is ignored.
- Reset: state=IDLE, kill=0, all registered fields 0.
  - Outputs after reset: out_mem_req_valid=0, out_rob_done=0, out_rob_value=0, out_rob_fault=0, out_rob_dst_rob_index=0, out_mem_addr=0, out_mem_wdata=0, out_mem_req_we=0.
  - out_fu_ready=1 from the first cycle after reset deasserts.
  - Reset mid-transaction abandons it with no done. A late response after reset is ignored.

Test Plan:
- Load, no stalls:
  - Stimulus: issue LDUR addr=0x100 dst=5; req_ready=1; response rdata=0xDEAD one cycle after acceptance.
  - Required: req_we=0, addr=0x100; single done pulse with dst=5, value=0xDEAD, fault=0, 3 cycles after acceptance; ready low from accept until the cycle after done.
- Store under backpressure:
  - Stimulus: issue STUR addr=0x208 data=42 dst=3; req_ready low for 3 cycles.
  - Required: valid held with addr and data stable for 3 cycles; accepted on the 4th; done dst=3 value=0 in the next cycle.
- Misaligned access:
  - Stimulus: issue LDUR addr=0x104 dst=7.
  - Required: no req_valid ever; done next cycle with fault=1, dst=7, value=0.
- Flush while waiting on a load:
  - Stimulus: load accepted by memory; mispred pulse in WAIT; response arrives 2 cycles later.
  - Required: no done pulse; ready returns the cycle after the response.
- Flush in REQ / flush with start:
  - Stimulus: store stalled in REQ, then mispred.
  - Required: req_valid drops next cycle; no write; no done.
  - Stimulus: start+mispred in the same cycle.
  - Required: issue ignored, unit stays IDLE.
- Reset and ignored inputs:
  - Stimulus: reset asserted in WAIT, then a stray response arrives after reset.
  - Required: all outputs 0; ready=1 after reset; stray response produces no done.
  - Stimulus: start while busy.
  - Required: ignored.
